// File: rtl/video_in_capture.sv
// Camera-style video receiver: oversamples clk_in in the clk domain, writes active pixels to a FIFO
// and checks frame geometry. Optional `VIDEO_IN_TEST_PATTERN_EN replaces pixels with counter sums.
module video_in_capture #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       clk_in,
  input  logic [7:0] pixel_in,
  input  logic       frame_valid_in,
  input  logic       line_valid_in,
  input  logic       fifo_full,
  output logic       w_en,
  output logic [7:0] w_data,
  input  logic       clr_err,
  output logic       frame_start,
  output logic       frame_done,
  output logic       err_line,
  output logic       err_frame,
  output logic       overflow
);

  localparam logic [10:0] WidthC  = 11'(WIDTH);
  localparam logic [9:0]  HeightL = 10'(HEIGHT);

  typedef enum logic [1:0] {StSync, StIdle, StActive, StDrop} state_e;

  state_e      r_state, w_state_d;
  logic        r_cin_s1, r_cin_s2, r_cin_h;
  logic        r_smp;
  logic [7:0]  r_pix;
  logic        r_fv, r_lv, r_fv_prev, r_lv_prev;
  logic [10:0] r_pix_c, w_pix_c_d, w_pix_c_inc;
  logic [9:0]  r_pix_l, w_pix_l_d, w_pix_l_inc, w_line_total;
  logic        r_err_line, r_err_frame, r_overflow;
  logic        w_err_line_d, w_err_frame_d, w_overflow_d;
  logic        w_strobe, w_fv_rise, w_fv_fall;

  // Falling edge of the synchronized source clock lands mid-period, when data is stable.
  assign w_strobe    = r_cin_h & ~r_cin_s2;
  assign w_fv_rise   = r_fv & ~r_fv_prev;
  assign w_fv_fall   = r_fv_prev & ~r_fv;
  assign w_pix_c_inc = (&r_pix_c) ? r_pix_c : r_pix_c + 11'd1;
  assign w_pix_l_inc = (&r_pix_l) ? r_pix_l : r_pix_l + 10'd1;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cin_s1    <= 1'b0;
      r_cin_s2    <= 1'b0;
      r_cin_h     <= 1'b0;
      r_smp       <= 1'b0;
      r_pix       <= 8'd0;
      r_fv        <= 1'b0;
      r_lv        <= 1'b0;
      r_fv_prev   <= 1'b0;
      r_lv_prev   <= 1'b0;
      r_state     <= StSync;
      r_pix_c     <= 11'd0;
      r_pix_l     <= 10'd0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_cin_s1    <= clk_in;
      r_cin_s2    <= r_cin_s1;
      r_cin_h     <= r_cin_s2;
      r_smp       <= w_strobe;
      if (w_strobe) begin
        r_pix     <= pixel_in;
        r_fv      <= frame_valid_in;
        r_lv      <= line_valid_in;
        r_fv_prev <= r_fv;
        r_lv_prev <= r_lv;
      end
      r_state     <= w_state_d;
      r_pix_c     <= w_pix_c_d;
      r_pix_l     <= w_pix_l_d;
      r_err_line  <= w_err_line_d;
      r_err_frame <= w_err_frame_d;
      r_overflow  <= w_overflow_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pix_c_d     = r_pix_c;
    w_pix_l_d     = r_pix_l;
    w_line_total  = r_pix_l;
    w_err_line_d  = clr_err ? 1'b0 : r_err_line;
    w_err_frame_d = clr_err ? 1'b0 : r_err_frame;
    w_overflow_d  = clr_err ? 1'b0 : r_overflow;
    w_en          = 1'b0;
    frame_start   = 1'b0;
    frame_done    = 1'b0;
    if (r_smp) begin
      case (r_state)
        StSync: if (!r_fv) w_state_d = StIdle;
        StIdle: begin
          if (w_fv_rise) begin
            frame_start = 1'b1;
            w_pix_c_d   = 11'd0;
            w_pix_l_d   = 10'd0;
            w_state_d   = StActive;
          end
        end
        StActive: begin
          if (w_fv_fall) begin
            // A line still open at frame end is closed before the line count is judged.
            if (r_lv_prev) begin
              if (r_pix_c != WidthC) w_err_line_d = 1'b1;
              w_line_total = w_pix_l_inc;
            end
            if (w_line_total != HeightL) w_err_frame_d = 1'b1;
            w_pix_c_d  = 11'd0;
            w_pix_l_d  = w_line_total;
            frame_done = 1'b1;
            w_state_d  = StIdle;
          end else if (r_fv) begin
            if (r_lv) begin
              if (!fifo_full) begin
                w_en      = 1'b1;
                w_pix_c_d = w_pix_c_inc;
              end else begin
                w_overflow_d = 1'b1;
                w_state_d    = StDrop;
              end
            end else if (r_lv_prev) begin
              if (r_pix_c != WidthC) w_err_line_d = 1'b1;
              w_pix_l_d = w_pix_l_inc;
              w_pix_c_d = 11'd0;
            end
          end
        end
        StDrop: begin
          if (w_fv_fall) begin
            frame_done = 1'b1;
            w_state_d  = StIdle;
          end
        end
        default: w_state_d = StSync;
      endcase
    end
  end

`ifdef VIDEO_IN_TEST_PATTERN_EN
  assign w_data = r_pix_c[7:0] + r_pix_l[7:0];
`else
  assign w_data = r_pix;
`endif

  assign err_line  = r_err_line;
  assign err_frame = r_err_frame;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_video_in_capture.sv
// Randomized bench for video_in_capture: a frame-level model predicts the written pixel stream,
// pulse counts and sticky flags; one compare process checks every FIFO write.
module tb_video_in_capture;
  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0, clk_in = 1'b0, nRST = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic       frame_valid_in = 1'b0, line_valid_in = 1'b0, fifo_full = 1'b0, clr_err = 1'b0;
  logic       w_en, frame_start, frame_done, err_line, err_frame, overflow;
  logic [7:0] w_data;

  video_in_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .nRST(nRST), .clk_in(clk_in), .pixel_in(pixel_in),
    .frame_valid_in(frame_valid_in), .line_valid_in(line_valid_in), .fifo_full(fifo_full),
    .w_en(w_en), .w_data(w_data), .clr_err(clr_err), .frame_start(frame_start),
    .frame_done(frame_done), .err_line(err_line), .err_frame(err_frame), .overflow(overflow)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #40 clk_in = ~clk_in;
  end

  int checks = 0, errors = 0;
  int wr_count = 0, starts = 0, dones = 0, cyc = 0, last_wr = -100;
  logic [7:0] exp_q[$];
  bit m_err_line, m_err_frame, m_ovf, armed;
  int m_starts = 0, m_dones = 0;
  int lens[$];
  int drop_at = -1, end_mode = 0, gap = 2, rst_ln = -1, rst_px = 0;
  bit rnd_px = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_px(input int p, input int ln, input logic [7:0] px);
`ifdef VIDEO_IN_TEST_PATTERN_EN
    return 8'(p + ln);
`else
    return px;
`endif
  endfunction

  // Compare process: every FIFO write must be the next predicted pixel, one per source period.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (nRST) begin
        if (w_en) begin
          wr_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("w_data", int'(w_data), int'(e));
          end
          check("write_spacing_ok", int'(cyc - last_wr >= 7), 1);
          last_wr = cyc;
        end
        if (frame_start) starts++;
        if (frame_done) dones++;
        if (frame_start && frame_done) check("start_done_same_cycle", 1, 0);
      end
    end
  end

  task automatic drive(input logic fv, input logic lv, input logic [7:0] px, input logic ff);
    @(posedge clk_in);
    frame_valid_in = fv;
    line_valid_in  = lv;
    pixel_in       = px;
    fifo_full      = ff;
  endtask

  task automatic set_lens(input int n, input int l);
    lens.delete();
    for (int i = 0; i < n; i++) lens.push_back(l);
  endtask

  task automatic send_frame();
    bit cap, dropped;
    int gidx, nl;
    logic ff;
    logic [7:0] px;
    cap = armed; dropped = 1'b0; gidx = 0; nl = 0; ff = 1'b0;
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    if (cap) m_starts++;
    for (int ln = 0; ln < lens.size(); ln++) begin
      for (int p = 0; p < lens[ln]; p++) begin
        if (drop_at == gidx) ff = 1'b1;
        px = rnd_px ? 8'($urandom) : 8'(gidx);
        drive(1'b1, 1'b1, px, ff);
        if (ln == rst_ln && p == rst_px) begin
          nRST = 1'b0;
          repeat (3) @(negedge clk);
          check("rst_w_en", int'(w_en), 0);
          check("rst_err_line", int'(err_line), 0);
          nRST = 1'b1;
          cap = 1'b0; armed = 1'b0;
          m_err_line = 1'b0; m_err_frame = 1'b0; m_ovf = 1'b0;
        end
        if (cap && !dropped) begin
          if (ff) begin
            dropped = 1'b1;
            m_ovf = 1'b1;
          end else begin
            exp_q.push_back(exp_px(p, ln, px));
          end
        end
        gidx++;
      end
      if (cap && !dropped) begin
        if (lens[ln] != W) m_err_line = 1'b1;
        nl++;
      end
      if (ln != lens.size() - 1 || end_mode == 0) repeat (gap) drive(1'b1, 1'b0, 8'd0, ff);
    end
    drive(1'b0, end_mode == 2, 8'd0, ff);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b0);
    if (cap) begin
      m_dones++;
      if (!dropped && nl != H) m_err_frame = 1'b1;
    end
    armed = 1'b1;
  endtask

  task automatic frame_check();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
    exp_q.delete();
    check("err_line", int'(err_line), int'(m_err_line));
    check("err_frame", int'(err_frame), int'(m_err_frame));
    check("overflow", int'(overflow), int'(m_ovf));
    check("frame_starts", starts, m_starts);
    check("frame_dones", dones, m_dones);
  endtask

  task automatic clear_flags();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    m_err_line = 1'b0; m_err_frame = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    check("clr_err_line", int'(err_line), 0);
    check("clr_err_frame", int'(err_frame), 0);
    check("clr_overflow", int'(overflow), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, tot;
    repeat (3) @(negedge clk);
    check("reset_w_en", int'(w_en), 0);
    check("reset_w_data", int'(w_data), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_err_line", int'(err_line), 0);
    check("reset_err_frame", int'(err_frame), 0);
    check("reset_overflow", int'(overflow), 0);
    nRST = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 8'd0, 1'b0);
    armed = 1'b1;

    // Clean frame, pixel values 0..31.
    set_lens(H, W);
    w0 = wr_count; send_frame(); frame_check();
    check("clean_writes", wr_count - w0, 32);
    check("clean_start_count", starts, 1);
    check("clean_err_any", int'(err_line | err_frame | overflow), 0);

    // Reset during line 2: only the 19 pixels before it are written, rest discarded.
    rst_ln = 2; rst_px = 3;
    w0 = wr_count; send_frame(); frame_check();
    rst_ln = -1;
    check("rst_writes", wr_count - w0, 19);
    rnd_px = 1'b1;
    w0 = wr_count; send_frame(); frame_check();
    check("after_rst_writes", wr_count - w0, 32);

    // Short line 1.
    lens[1] = 7;
    w0 = wr_count; send_frame(); frame_check();
    check("short_writes", wr_count - w0, 31);
    check("short_err_line", int'(err_line), 1);
    check("short_err_frame", int'(err_frame), 0);
    clear_flags();

    // Overflow at pixel 10.
    set_lens(H, W); drop_at = 10;
    w0 = wr_count; send_frame(); frame_check();
    check("ovf_writes", wr_count - w0, 10);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_err_frame", int'(err_frame), 0);
    clear_flags();
    drop_at = -1;
    w0 = wr_count; send_frame(); frame_check();
    check("post_ovf_writes", wr_count - w0, 32);

    // lv and fv fall together on the last line.
    end_mode = 1;
    send_frame(); frame_check();
    check("simfall4_err_frame", int'(err_frame), 0);
    set_lens(H + 1, W);
    send_frame(); frame_check();
    check("simfall5_err_frame", int'(err_frame), 1);
    clear_flags();
    // lv still high when fv falls.
    end_mode = 2; set_lens(H, W);
    send_frame(); frame_check();
    check("lvhigh_err_any", int'(err_line | err_frame), 0);

    repeat (14) begin
      lens.delete();
      tot = 0;
      for (int i = 0, n = $urandom_range(3, 5); i < n; i++) begin
        lens.push_back(($urandom % 4 == 0) ? 7 + 2 * int'($urandom % 2) : 8);
        tot += lens[i];
      end
      drop_at  = ($urandom % 3 == 0) ? int'($urandom_range(0, tot - 1)) : -1;
      end_mode = int'($urandom % 3);
      gap      = int'($urandom_range(1, 3));
      send_frame(); frame_check();
      if ($urandom % 2 == 1) clear_flags();
      repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom), 8'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_in_capture.md
Name: video_in_capture

Overview:
- Receive side of the camera-style video interface: 8-bit pixel bus plus frame_valid/line_valid, all synchronous to the source clock clk_in.
- Oversamples the stream in the clk domain and writes every active pixel into the pixel FIFO with single-cycle write pulses.
- Checks frame geometry against WIDTH/HEIGHT and flags overflow and geometry errors.
- Sits between the sensor/video source pins and the FIFO feeding the processing pipeline.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.

Ports:
- clk  in  1  system clock; frequency >= 4x clk_in.
- nRST  in  1  reset, asynchronous, active-low.
- clk_in  in  1  video source clock; source launches data on its rising edge.
- pixel_in  in  8  source pixel.
- frame_valid_in  in  1  source frame valid.
- line_valid_in  in  1  source line valid.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- w_en  out  1  one-clk FIFO write strobe.
- w_data  out  8  pixel written when w_en=1.
- clr_err  in  1  clears the sticky error flags.
- frame_start  out  1  one-clk pulse when a captured frame begins.
- frame_done  out  1  one-clk pulse when a captured frame ends.
- err_line  out  1  sticky; a line length differed from WIDTH.
- err_frame  out  1  sticky; a line count differed from HEIGHT.
- overflow  out  1  sticky; a pixel was dropped because fifo_full=1.

Behaviour:
- Reset: all outputs 0, counters 0, state SYNC.
- clk_in passes through a 2-flop synchronizer plus one history flop.
- Sample strobe s fires for one clk cycle on a detected falling edge of synced clk_in, i.e. mid-period, when the data is stable.
- On s, register pixel_in, fv = frame_valid_in, lv = line_valid_in, and hold the previous fv/lv for edge detection.
- All protocol decisions below happen only in the clk cycle after s.
- States:
  - SYNC: wait for a sample with fv=0, then go to IDLE. This prevents capturing a partial frame after reset.
  - IDLE: on a sample with fv=1 (rising fv), pulse frame_start, clear pixel_c and pixel_l, go to ACTIVE.
  - ACTIVE, sample with lv=1:
    - fifo_full=0: w_en=1 for one clk with w_data = sampled pixel; pixel_c++.
    - fifo_full=1: no write, set overflow, go to DROP.
  - ACTIVE, lv falling (prev lv=1, lv=0):
    - set err_line if pixel_c != WIDTH;
    - pixel_l++, pixel_c <= 0.
  - ACTIVE, fv falling:
    - if lv also fell, or lv was still high, apply the line-end processing first;
    - then set err_frame if the final pixel_l != HEIGHT;
    - pulse frame_done, go to IDLE.
  - DROP: ignore all pixels; on fv falling pulse frame_done (no geometry check), go to IDLE.
- lv=1 while fv=0 is ignored in every state.
- Counter widths: pixel_c 11 bits, pixel_l 10 bits, both saturating at all-ones (no wrap). Saturation also makes the count mismatch, so the matching error flag sets.
- Latency: w_en asserts exactly 1 clk after s.
- Write rate: at most one w_en per clk_in period.
- Sticky flags:
  - cleared only by clr_err=1 (synchronous) or by reset;
  - if clr_err and a set condition occur in the same cycle, set wins.
- frame_start and frame_done never assert in the same cycle.
- Reset mid-frame: immediate return to SYNC; the rest of that frame is discarded.

Optional Feature:
- Macro: VIDEO_IN_TEST_PATTERN_EN.
- Defined: w_data = (pixel_c + pixel_l) mod 256, using the counter values before the increment; pixel_in is ignored. Timing, handshake and checks are unchanged.
- Undefined: w_data = sampled pixel_in; no pattern logic is synthesized.

Test Plan:
- Bench instance: WIDTH=8, HEIGHT=4, clk = 8x clk_in.
- Clean frame: fv up, 4 lines of 8 pixels (values 0..31), 2-cycle line gaps, fv down -> 32 w_en pulses, w_data 0..31 in order, one frame_start, one frame_done, no flags set.
- Reset mid-frame: nRST low during line 2, released while fv=1 -> no writes until fv has dropped and risen again; the next full frame is captured correctly.
- Short line: line 1 has 7 pixels -> err_line=1 at its lv fall, err_frame=0, 31 writes; clr_err pulse -> err_line=0.
- Overflow: fifo_full=1 at pixel 10 -> 10 writes only, overflow=1, frame_done on fv fall, err_frame=0; next frame is captured fully.
- Simultaneous fall: lv and fv drop on the same sample after line 3 -> pixel_l=4, no err_frame; 5 lines -> err_frame=1.
- VIDEO_IN_TEST_PATTERN_EN defined: clean frame -> line 2 w_data = 2..9 regardless of pixel_in.
